// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Main sequencing FSM of the multi-cycle CPU. Each instruction walks through
// IF -> ID -> EX -> MEM -> WB, skipping the phases its opcode does not need.
// This block is the only source of the register-file phase strobes, so the
// register file reads only in ID and writes only in WB.
//
// Parameters
//   OP_W   opcode width (MIPS-style op field)
//   CNT_W  retired-instruction counter width
//
// Ports
//   clk                  clock, rising edge
//   rst                  asynchronous reset, active low
//   op                   opcode field from the IR (decoded live in ID only)
//   imem_ready           instruction memory word available
//   dmem_ready           data memory access complete
//   state                current state: IF=0 ID=1 EX=2 MEM=3 WB=4
//   state_regfile_read   high in ID
//   state_regfile_write  high in WB
//   reg_we               register file write enable (WB)
//   reg_dst              1 = rd (R-type), 0 = rt; meaningful in WB
//   mem_to_reg           1 for lw; meaningful in WB
//   imem_req             instruction fetch request (IF)
//   ir_we, pc_we         IR / PC write enables on the fetch handshake cycle
//   pc_src               0 = PC+4, 1 = branch target, 2 = jump target
//   branch_en            EX of beq; the datapath ANDs it with ALU zero
//   jump_we              ID of j
//   dmem_req, dmem_we    data memory request / write (MEM)
//   illegal_op           one-cycle pulse in ID on an unknown opcode
//   retire               one-cycle pulse on the last cycle of an instruction
//   instr_count          retired-instruction count, wraps
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  op,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic             state_regfile_read,
    output logic             state_regfile_write,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             branch_en,
    output logic             jump_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             illegal_op,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_LW, C_SW, C_BEQ, C_J, C_ADDI, C_ORI, C_LUI, C_ILL
    } op_class_t;

    localparam logic [OP_W-1:0] OPC_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OPC_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OPC_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OPC_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OPC_J    = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OPC_ORI  = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OPC_LUI  = OP_W'(6'b001111);

    function automatic op_class_t classify(input logic [OP_W-1:0] o);
        op_class_t c;
        case (o)
            OPC_R:    c = C_R;
            OPC_LW:   c = C_LW;
            OPC_SW:   c = C_SW;
            OPC_BEQ:  c = C_BEQ;
            OPC_J:    c = C_J;
            OPC_ADDI: c = C_ADDI;
            OPC_ORI:  c = C_ORI;
            OPC_LUI:  c = C_LUI;
            default:  c = C_ILL;
        endcase
        return c;
    endfunction

    state_t           state_reg;
    logic [OP_W-1:0]  op_q_reg;
    logic [CNT_W-1:0] instr_count_reg;

    op_class_t id_cls;   // live decode, only meaningful in ID
    op_class_t q_cls;    // decode of the captured opcode for EX/MEM/WB

    assign id_cls = classify(op);
    assign q_cls  = classify(op_q_reg);

    // Unmasked output values; gated with rst below so every output is
    // forced low while reset is held, independent of the flop state.
    logic       rf_read_c, rf_write_c, reg_we_c, reg_dst_c, mem_to_reg_c;
    logic       imem_req_c, ir_we_c, pc_we_c, branch_en_c, jump_we_c;
    logic       dmem_req_c, dmem_we_c, illegal_op_c, retire_c;
    logic [1:0] pc_src_c;

    always_comb begin
        rf_read_c    = 1'b0;
        rf_write_c   = 1'b0;
        reg_we_c     = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        imem_req_c   = 1'b0;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = 2'd0;
        branch_en_c  = 1'b0;
        jump_we_c    = 1'b0;
        dmem_req_c   = 1'b0;
        dmem_we_c    = 1'b0;
        illegal_op_c = 1'b0;
        retire_c     = 1'b0;
        case (state_reg)
            S_IF: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                end
            end
            S_ID: begin
                rf_read_c = 1'b1;
                if (id_cls == C_J) begin
                    jump_we_c = 1'b1;
                    pc_src_c  = 2'd2;
                    retire_c  = 1'b1;
                end else if (id_cls == C_ILL) begin
                    illegal_op_c = 1'b1;
                end
            end
            S_EX: begin
                if (q_cls == C_BEQ) begin
                    branch_en_c = 1'b1;
                    pc_src_c    = 2'd1;
                    retire_c    = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (q_cls == C_SW);
                // A store finishes on its handshake cycle; a load still needs WB.
                retire_c   = dmem_ready && (q_cls == C_SW);
            end
            S_WB: begin
                rf_write_c   = 1'b1;
                reg_we_c     = 1'b1;
                reg_dst_c    = (q_cls == C_R);
                mem_to_reg_c = (q_cls == C_LW);
                retire_c     = 1'b1;
            end
            default: ;  // encodings 5..7: all outputs stay low
        endcase
    end

    // Sequencer: state, captured opcode and retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IF;
            op_q_reg        <= '0;
            instr_count_reg <= '0;
        end else begin
            if (retire_c) begin
                instr_count_reg <= instr_count_reg + CNT_W'(1);
            end
            case (state_reg)
                S_IF: begin
                    if (imem_ready) state_reg <= S_ID;
                end
                S_ID: begin
                    op_q_reg <= op;
                    if (id_cls == C_J || id_cls == C_ILL) state_reg <= S_IF;
                    else                                   state_reg <= S_EX;
                end
                S_EX: begin
                    case (q_cls)
                        C_BEQ:                      state_reg <= S_IF;
                        C_LW, C_SW:                 state_reg <= S_MEM;
                        C_R, C_ADDI, C_ORI, C_LUI:  state_reg <= S_WB;
                        default:                    state_reg <= S_IF;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        state_reg <= (q_cls == C_LW) ? S_WB : S_IF;
                    end
                end
                S_WB:    state_reg <= S_IF;
                default: state_reg <= S_IF;
            endcase
        end
    end

    assign state               = state_reg;
    assign instr_count         = instr_count_reg;
    assign state_regfile_read  = rst & rf_read_c;
    assign state_regfile_write = rst & rf_write_c;
    assign reg_we              = rst & reg_we_c;
    assign reg_dst             = rst & reg_dst_c;
    assign mem_to_reg          = rst & mem_to_reg_c;
    assign imem_req            = rst & imem_req_c;
    assign ir_we               = rst & ir_we_c;
    assign pc_we               = rst & pc_we_c;
    assign pc_src              = rst ? pc_src_c : 2'd0;
    assign branch_en           = rst & branch_en_c;
    assign jump_we             = rst & jump_we_c;
    assign dmem_req            = rst & dmem_req_c;
    assign dmem_we             = rst & dmem_we_c;
    assign illegal_op          = rst & illegal_op_c;
    assign retire              = rst & retire_c;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//
// Scoreboard bench. The stimulus process plans each instruction as a list
// of phases (IF waits, ID, EX, MEM waits, WB) from the opcode rules, drives
// the inputs cycle by cycle along that plan and pushes the expected
// per-instruction summary. The monitor accumulates what the DUT actually
// did and compares when it sees retire or illegal_op.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

    localparam int OP_W  = 6;
    localparam int CNT_W = 32;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_ORI  = 6'h0D;
    localparam logic [5:0] OPC_LUI  = 6'h0F;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [OP_W-1:0]  op = '0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic [2:0]       state;
    logic             state_regfile_read, state_regfile_write, reg_we, reg_dst;
    logic             mem_to_reg, imem_req, ir_we, pc_we, branch_en, jump_we;
    logic             dmem_req, dmem_we, illegal_op, retire;
    logic [1:0]       pc_src;
    logic [CNT_W-1:0] instr_count;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .op                  (op),
        .imem_ready          (imem_ready),
        .dmem_ready          (dmem_ready),
        .state               (state),
        .state_regfile_read  (state_regfile_read),
        .state_regfile_write (state_regfile_write),
        .reg_we              (reg_we),
        .reg_dst             (reg_dst),
        .mem_to_reg          (mem_to_reg),
        .imem_req            (imem_req),
        .ir_we               (ir_we),
        .pc_we               (pc_we),
        .pc_src              (pc_src),
        .branch_en           (branch_en),
        .jump_we             (jump_we),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .illegal_op          (illegal_op),
        .retire              (retire),
        .instr_count         (instr_count)
    );

    // Per-instruction summary: visited-state trace, length, and how many
    // cycles each strobe was high.
    typedef struct packed {
        logic [63:0] trace;
        logic [7:0]  len;
        logic [7:0]  n_imem, n_irwe, n_pcwe, n_rd, n_jump, n_ill, n_br;
        logic [7:0]  n_dreq, n_dwe, n_rwe, n_wr, n_ret;
        logic        reg_dst;
        logic        m2r;
        logic [1:0]  pc_src_ev;
        logic        pcwe_src_nz;
        logic [31:0] cnt;
    } rec_t;

    rec_t        exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] model_cnt = '0;
    logic [5:0]  legal_ops [8] = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ,
                                   OPC_J, OPC_ADDI, OPC_ORI, OPC_LUI};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    rec_t acc = '0;
    rec_t mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            acc = '0;
        end else begin
            acc.trace  = {acc.trace[60:0], state};
            acc.len    = acc.len    + 8'(1);
            acc.n_imem = acc.n_imem + 8'(imem_req);
            acc.n_irwe = acc.n_irwe + 8'(ir_we);
            acc.n_pcwe = acc.n_pcwe + 8'(pc_we);
            acc.n_rd   = acc.n_rd   + 8'(state_regfile_read);
            acc.n_jump = acc.n_jump + 8'(jump_we);
            acc.n_ill  = acc.n_ill  + 8'(illegal_op);
            acc.n_br   = acc.n_br   + 8'(branch_en);
            acc.n_dreq = acc.n_dreq + 8'(dmem_req);
            acc.n_dwe  = acc.n_dwe  + 8'(dmem_we);
            acc.n_rwe  = acc.n_rwe  + 8'(reg_we);
            acc.n_wr   = acc.n_wr   + 8'(state_regfile_write);
            acc.n_ret  = acc.n_ret  + 8'(retire);
            if (reg_we) begin
                acc.reg_dst = acc.reg_dst | reg_dst;
                acc.m2r     = acc.m2r | mem_to_reg;
            end
            if (pc_we && pc_src != 2'd0) acc.pcwe_src_nz = 1'b1;
            if (retire || illegal_op) begin
                acc.pc_src_ev = pc_src;
                acc.cnt       = instr_count;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got %h required none", acc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (acc !== mon_e) begin
                        n_fail++;
                        $display("FAIL instr_summary: got %h required %h", acc, mon_e);
                    end else begin
                        $display("txn ok len=%0d retire=%0d illegal=%0d count=%h",
                                 acc.len, acc.n_ret, acc.n_ill, acc.cnt);
                    end
                end
                acc = '0;
            end else if (acc.len > 8'd60) begin
                n_vec++;
                n_fail++;
                $display("FAIL watchdog: got no event in %0d cycles required one", acc.len);
                acc = '0;
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic run_instr(input logic [5:0] o, input int wi, input int wd, input bit abort_wb);
        int   ph[$];
        rec_t e;
        bit   legal, is_j, is_beq, is_lw, is_sw, is_r, mem, wb;
        int   if_idx, mem_idx;
        legal = 1'b0;
        for (int i = 0; i < 8; i++) if (legal_ops[i] == o) legal = 1'b1;
        is_j   = (o == OPC_J);
        is_beq = (o == OPC_BEQ);
        is_lw  = (o == OPC_LW);
        is_sw  = (o == OPC_SW);
        is_r   = (o == OPC_R);
        mem    = is_lw || is_sw;
        wb     = legal && !is_j && !is_beq && !is_sw;

        for (int i = 0; i <= wi; i++) ph.push_back(0);
        ph.push_back(1);
        if (legal && !is_j) ph.push_back(2);
        if (mem) for (int i = 0; i <= wd; i++) ph.push_back(3);
        if (wb) ph.push_back(4);

        e = '0;
        foreach (ph[k]) e.trace = {e.trace[60:0], 3'(ph[k])};
        e.len       = 8'(ph.size());
        e.n_imem    = 8'(wi + 1);
        e.n_irwe    = 8'd1;
        e.n_pcwe    = 8'd1;
        e.n_rd      = 8'd1;
        e.n_jump    = 8'(is_j);
        e.n_ill     = 8'(!legal);
        e.n_br      = 8'(is_beq);
        e.n_dreq    = mem ? 8'(wd + 1) : 8'd0;
        e.n_dwe     = is_sw ? 8'(wd + 1) : 8'd0;
        e.n_rwe     = 8'(wb);
        e.n_wr      = 8'(wb);
        e.n_ret     = 8'(legal);
        e.reg_dst   = is_r;
        e.m2r       = is_lw;
        e.pc_src_ev = is_j ? 2'd2 : (is_beq ? 2'd1 : 2'd0);
        e.cnt       = model_cnt;
        if (!abort_wb) begin
            exp_q.push_back(e);
            if (legal) model_cnt = model_cnt + 32'd1;
        end

        if_idx  = 0;
        mem_idx = 0;
        for (int k = 0; k < ph.size(); k++) begin
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            op         = 6'($urandom);
            case (ph[k])
                0: begin imem_ready = (if_idx == wi); if_idx++; end
                1: op = o;
                3: begin dmem_ready = (mem_idx == wd); mem_idx++; end
                4: if (abort_wb) begin
                    check("wb_before_reset", {61'd0, state}, 64'd4);
                    check("reg_we_before_reset", 64'(reg_we), 64'd1);
                    rst = 1'b0;
                    #1;
                    check("reg_we_in_reset", 64'(reg_we), 64'd0);
                    check("state_in_reset", {61'd0, state}, 64'd0);
                    check("retire_in_reset", 64'(retire), 64'd0);
                    @(posedge clk);
                    #1;
                    check("imem_req_in_reset", 64'(imem_req), 64'd0);
                    rst = 1'b1;
                    model_cnt = '0;
                    #1;
                    check("imem_req_after_reset", 64'(imem_req), 64'd1);
                    check("count_after_reset", 64'(instr_count), 64'(model_cnt));
                    return;
                end
                default: ;
            endcase
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] o;
        // Reset held with readies high: everything must stay at zero.
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        op         = 6'h3F;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({state, state_regfile_read, state_regfile_write, reg_we, reg_dst,
                   mem_to_reg, imem_req, ir_we, pc_we, pc_src, branch_en, jump_we,
                   dmem_req, dmem_we, illegal_op, retire}), 64'd0);
        check("reset_count", 64'(instr_count), 64'd0);
        rst = 1'b1;
        #1;
        check("first_imem_req", 64'(imem_req), 64'd1);

        run_instr(OPC_R,   0, 0, 1'b0);
        run_instr(OPC_LW,  0, 3, 1'b0);
        run_instr(OPC_SW,  0, 0, 1'b0);
        run_instr(OPC_BEQ, 0, 0, 1'b0);
        run_instr(OPC_J,   0, 0, 1'b0);
        run_instr(6'h3F,   0, 0, 1'b0);
        run_instr(OPC_ORI, 1, 0, 1'b1);   // reset lands in WB
        run_instr(OPC_LUI, 0, 0, 1'b0);

        // Preload the counter just below wrap, then retire one addi.
        force dut.instr_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_reg;
        model_cnt = 32'hFFFF_FFFF;
        check("count_preload", 64'(instr_count), 64'hFFFF_FFFF);
        run_instr(OPC_ADDI, 3, 0, 1'b0);
        check("count_wrapped", 64'(instr_count), 64'd0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            else                           o = legal_ops[$urandom_range(0, 7)];
            run_instr(o, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
        end

        imem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_count", 64'(instr_count), 64'(model_cnt));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
